// File: rtl/adder_share_arbiter_pkg.sv
// Shared types and helpers for the shared-adder arbiter: FSM state encoding
// and the requester-index width calculation.
package adder_share_arbiter_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   // Index width for r requesters, never narrower than one bit.
   function automatic int calc_iw(input int r);
      return (r > 1) ? $clog2(r) : 1;
   endfunction

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Request/response bundle between R requesters, the shared adder and its
// single downstream consumer.
interface adder_share_arbiter_if
   import adder_share_arbiter_pkg::*;
#(
   parameter int N = 32,
   parameter int R = 4
) ();
   localparam int IW = calc_iw(R);

   logic [R-1:0]         req_valid;
   logic [R-1:0]         req_ready;
   logic [R-1:0][N-1:0]  req_a;
   logic [R-1:0][N-1:0]  req_b;
   logic [R-1:0]         req_carry_in;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [IW-1:0]        rsp_id;
   logic [N-1:0]         rsp_sum;
   logic                 rsp_carry_out;

   // Arbiter side.
   modport slave (
      input  req_valid, req_a, req_b, req_carry_in, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry_out
   );

   // Requesters plus downstream consumer.
   modport master (
      output req_valid, req_a, req_b, req_carry_in, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry_out
   );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin grant: scans from last_grant+1 upward, wrapping, and grants the
// first active request as a one-hot vector plus its index.
module rr_arbiter #(
   parameter int R  = 4,
   parameter int IW = 2
) (
   input  logic [R-1:0]  req,
   input  logic [IW-1:0] last_grant,
   output logic [R-1:0]  grant,
   output logic [IW-1:0] grant_idx
);

   logic          found;
   logic [IW-1:0] idx;

   // Offsets 1..R visit every requester once, last_grant itself last.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = '0;
      for (int k = 1; k <= R; k++) begin
         idx = IW'((int'(last_grant) + k) % R);
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/adder_share_arbiter.sv
// One N+1-bit adder shared by R requesters through a round-robin arbiter,
// with a single result register that sustains one operation per cycle.
module adder_share_arbiter
   import adder_share_arbiter_pkg::*;
#(
   parameter int N = 32,
   parameter int R = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   adder_share_arbiter_if.slave bus
);
   localparam int IW = calc_iw(R);

   state_t         state_reg;
   logic           rsp_valid_reg;
   logic [N-1:0]   rsp_sum_reg;
   logic           rsp_carry_out_reg;
   logic [IW-1:0]  rsp_id_reg;
   logic [IW-1:0]  last_grant_reg;

   logic [R-1:0]   grant;
   logic [IW-1:0]  grant_idx;
   logic [R-1:0]   ready_vec;
   logic           can_accept;
   logic           accept;
   logic [N-1:0]   sel_a;
   logic [N-1:0]   sel_b;
   logic           sel_cin;
   logic [N:0]     sum_next;

   rr_arbiter #(
      .R  (R),
      .IW (IW)
   ) u_rr_arbiter (
      .req        (bus.req_valid),
      .last_grant (last_grant_reg),
      .grant      (grant),
      .grant_idx  (grant_idx)
   );

   // Gating with rst_n keeps every ready low for the whole reset window.
   assign can_accept = rst_n && ((state_reg == EMPTY) || (rsp_valid_reg && bus.rsp_ready));

   generate
      for (genvar gi = 0; gi < R; gi++) begin : g_ready
         assign ready_vec[gi] = grant[gi] & can_accept;
      end
   endgenerate

   assign bus.req_ready = ready_vec;
   assign accept        = |ready_vec;

   // One-hot AND-OR operand mux in front of the single adder.
   always_comb begin
      sel_a   = '0;
      sel_b   = '0;
      sel_cin = 1'b0;
      for (int i = 0; i < R; i++) begin
         if (grant[i]) begin
            sel_a   = sel_a | bus.req_a[i];
            sel_b   = sel_b | bus.req_b[i];
            sel_cin = sel_cin | bus.req_carry_in[i];
         end
      end
   end

   assign sum_next = {1'b0, sel_a} + {1'b0, sel_b} + {{N{1'b0}}, sel_cin};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg         <= EMPTY;
         rsp_valid_reg     <= 1'b0;
         rsp_sum_reg       <= '0;
         rsp_carry_out_reg <= 1'b0;
         rsp_id_reg        <= '0;
         last_grant_reg    <= IW'(R - 1);
      end else begin
         case (state_reg)
            EMPTY: begin
               if (accept) begin
                  state_reg     <= FULL;
                  rsp_valid_reg <= 1'b1;
               end
            end
            FULL: begin
               if (!accept && bus.rsp_ready) begin
                  state_reg     <= EMPTY;
                  rsp_valid_reg <= 1'b0;
               end
            end
            default: begin
               state_reg     <= EMPTY;
               rsp_valid_reg <= 1'b0;
            end
         endcase
         // A drain-and-accept in FULL reloads the register in the same edge.
         if (accept) begin
            rsp_sum_reg       <= sum_next[N-1:0];
            rsp_carry_out_reg <= sum_next[N];
            rsp_id_reg        <= grant_idx;
            last_grant_reg    <= grant_idx;
         end
      end
   end

   assign bus.rsp_valid     = rsp_valid_reg;
   assign bus.rsp_sum       = rsp_sum_reg;
   assign bus.rsp_carry_out = rsp_carry_out_reg;
   assign bus.rsp_id        = rsp_id_reg;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: scenario tasks plus a cycle monitor holding a
// round-robin reference and a response scoreboard.
module tb_adder_share_arbiter;
   import adder_share_arbiter_pkg::*;

   localparam int N  = 32;
   localparam int R  = 4;
   localparam int IW = calc_iw(R);

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   always #5 clk = ~clk;

   adder_share_arbiter_if #(.N(N), .R(R)) ifc ();

   adder_share_arbiter #(.N(N), .R(R)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         id;
      logic [N:0] res;
   } exp_t;

   exp_t sb[$];
   bit   m_full = 1'b0;
   int   m_last = R - 1;

   function automatic int rr_pick(input logic [R-1:0] v, input int last);
      for (int k = 1; k <= R; k++) begin
         int i;
         i = (last + k) % R;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [N:0] ref_add(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
      logic [N:0] s;
      s = {1'b0, a} + {1'b0, b};
      s = s + (N+1)'(c);
      return s;
   endfunction

   // Reference model, evaluated mid-cycle; the state it updates takes effect at the next edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         m_full = 1'b0;
         m_last = R - 1;
         sb.delete();
         checks++;
         if (ifc.req_ready !== '0 || ifc.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL mon_reset: req_ready=%b rsp_valid=%b, required 0 and 0", ifc.req_ready, ifc.rsp_valid);
         end
      end else begin
         logic [R-1:0] exp_ready;
         bit           can;
         int           pick;
         exp_t         e;
         checks++;
         if (ifc.rsp_valid !== m_full) begin
            errors++;
            $display("FAIL mon_rsp_valid: got %b, required %b", ifc.rsp_valid, m_full);
         end
         if (m_full && ifc.rsp_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL sb_underflow: response drained with no outstanding request");
            end else begin
               e = sb.pop_front();
               if (int'(ifc.rsp_id) !== e.id || {ifc.rsp_carry_out, ifc.rsp_sum} !== e.res) begin
                  errors++;
                  $display("FAIL sb_result: id=%0d cout_sum=%h, required id=%0d cout_sum=%h",
                           ifc.rsp_id, {ifc.rsp_carry_out, ifc.rsp_sum}, e.id, e.res);
               end
            end
         end
         can       = !m_full || (ifc.rsp_ready === 1'b1);
         pick      = rr_pick(ifc.req_valid, m_last);
         exp_ready = '0;
         if (can && pick >= 0) exp_ready[pick] = 1'b1;
         checks++;
         if (ifc.req_ready !== exp_ready) begin
            errors++;
            $display("FAIL mon_req_ready: got %b, required %b", ifc.req_ready, exp_ready);
         end
         if (exp_ready != '0) begin
            e.id  = pick;
            e.res = ref_add(ifc.req_a[pick], ifc.req_b[pick], ifc.req_carry_in[pick]);
            sb.push_back(e);
            m_last = pick;
            m_full = 1'b1;
         end else if (ifc.rsp_ready) begin
            m_full = 1'b0;
         end
      end
   end

   task automatic clear_inputs();
      ifc.req_valid    = '0;
      ifc.req_a        = '0;
      ifc.req_b        = '0;
      ifc.req_carry_in = '0;
      ifc.rsp_ready    = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      ifc.req_valid = '1;
      ifc.rsp_ready = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (ifc.req_ready !== '0 || ifc.rsp_valid !== 1'b0 || ifc.rsp_sum !== '0 ||
          ifc.rsp_carry_out !== 1'b0 || ifc.rsp_id !== '0) begin
         errors++;
         $display("FAIL reset_values: ready=%b valid=%b sum=%h cout=%b id=%0d, required all zero",
                  ifc.req_ready, ifc.rsp_valid, ifc.rsp_sum, ifc.rsp_carry_out, ifc.rsp_id);
      end
      @(posedge clk); #2;
      rst_n = 1'b1;
      clear_inputs();
      $display("reset: released");
   endtask

   task automatic test_fairness();
      @(posedge clk); #1;
      for (int i = 0; i < R; i++) begin
         ifc.req_a[i]        = N'(32'h1000_0000 * (i + 1) + i);
         ifc.req_b[i]        = N'(32'h0F00_00F0 + i * 7);
         ifc.req_carry_in[i] = i[0];
      end
      ifc.req_valid = '1;
      ifc.rsp_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         int got;
         @(negedge clk);
         got = -1;
         for (int i = 0; i < R; i++) if (ifc.req_ready[i]) got = i;
         checks++;
         if (got !== c % R) begin
            errors++;
            $display("FAIL fair_grant: cycle %0d granted %0d, required %0d", c, got, c % R);
         end
         if (c > 0) begin
            checks++;
            if (ifc.rsp_valid !== 1'b1 || int'(ifc.rsp_id) !== (c - 1) % R) begin
               errors++;
               $display("FAIL fair_rsp: cycle %0d valid=%b id=%0d, required 1 and %0d",
                        c, ifc.rsp_valid, ifc.rsp_id, (c - 1) % R);
            end
         end
         $display("fairness: cycle %0d grant %0d", c, got);
      end
      @(posedge clk); #1;
      ifc.req_valid = '0;
   endtask

   task automatic test_single_request();
      @(posedge clk); #1;
      clear_inputs();
      ifc.req_valid[0] = 1'b1;
      ifc.req_a[0]     = 32'h0000_0001;
      ifc.req_b[0]     = 32'hFFFF_FFFF;
      @(negedge clk);
      checks++;
      if (ifc.req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL single_ready: got %b, required 0001", ifc.req_ready);
      end
      @(posedge clk); #1;
      ifc.req_valid = '0;
      checks++;
      if (ifc.rsp_valid !== 1'b1 || ifc.rsp_sum !== 32'h0 || ifc.rsp_carry_out !== 1'b1 || ifc.rsp_id !== 2'd0) begin
         errors++;
         $display("FAIL single_rsp: valid=%b sum=%h cout=%b id=%0d, required 1 00000000 1 0",
                  ifc.rsp_valid, ifc.rsp_sum, ifc.rsp_carry_out, ifc.rsp_id);
      end
      $display("single: sum=%h cout=%b id=%0d", ifc.rsp_sum, ifc.rsp_carry_out, ifc.rsp_id);
      ifc.rsp_ready = 1'b1;
      @(posedge clk); #1;
      ifc.rsp_ready = 1'b0;
      checks++;
      if (ifc.rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_drain: rsp_valid=%b, required 0", ifc.rsp_valid);
      end
   endtask

   task automatic test_backpressure();
      logic [N:0] exp1;
      logic [N:0] exp2;
      @(posedge clk); #1;
      clear_inputs();
      ifc.req_a[1] = 32'h8000_0001; ifc.req_b[1] = 32'h8000_0002; ifc.req_carry_in[1] = 1'b1;
      ifc.req_a[2] = 32'h1234_5678; ifc.req_b[2] = 32'h1111_1111; ifc.req_carry_in[2] = 1'b0;
      exp1 = 33'h1_0000_0004;
      exp2 = 33'h0_2345_6789;
      ifc.req_valid = 4'b0110;
      @(posedge clk); #1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (ifc.req_ready !== '0 || ifc.rsp_valid !== 1'b1 || ifc.rsp_id !== 2'd1 ||
             {ifc.rsp_carry_out, ifc.rsp_sum} !== exp1) begin
            errors++;
            $display("FAIL bp_hold: cycle %0d ready=%b valid=%b id=%0d cout_sum=%h, required 0000 1 1 %h",
                     c, ifc.req_ready, ifc.rsp_valid, ifc.rsp_id, {ifc.rsp_carry_out, ifc.rsp_sum}, exp1);
         end
         $display("backpressure: hold cycle %0d id=%0d", c, ifc.rsp_id);
      end
      @(posedge clk); #1;
      ifc.rsp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (ifc.req_ready !== 4'b0100) begin
         errors++;
         $display("FAIL bp_drain_accept: ready=%b, required 0100", ifc.req_ready);
      end
      @(posedge clk); #1;
      ifc.req_valid = '0;
      checks++;
      if (ifc.rsp_valid !== 1'b1 || ifc.rsp_id !== 2'd2 || {ifc.rsp_carry_out, ifc.rsp_sum} !== exp2) begin
         errors++;
         $display("FAIL bp_next: valid=%b id=%0d cout_sum=%h, required 1 2 %h",
                  ifc.rsp_valid, ifc.rsp_id, {ifc.rsp_carry_out, ifc.rsp_sum}, exp2);
      end
      @(posedge clk); #1;
      ifc.rsp_ready = 1'b0;
   endtask

   task automatic test_carry_overflow();
      @(posedge clk); #1;
      clear_inputs();
      ifc.req_a[3]        = 32'hFFFF_FFFF;
      ifc.req_b[3]        = 32'hFFFF_FFFF;
      ifc.req_carry_in[3] = 1'b1;
      ifc.req_valid       = 4'b1000;
      @(posedge clk); #1;
      ifc.req_valid = '0;
      checks++;
      if (ifc.rsp_sum !== 32'hFFFF_FFFF || ifc.rsp_carry_out !== 1'b1 || ifc.rsp_id !== 2'd3) begin
         errors++;
         $display("FAIL overflow: sum=%h cout=%b id=%0d, required ffffffff 1 3",
                  ifc.rsp_sum, ifc.rsp_carry_out, ifc.rsp_id);
      end
      $display("overflow: sum=%h cout=%b", ifc.rsp_sum, ifc.rsp_carry_out);
      ifc.rsp_ready = 1'b1;
      @(posedge clk); #1;
      ifc.rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid_op();
      @(posedge clk); #1;
      clear_inputs();
      ifc.req_a[2]  = 32'h0000_00AA;
      ifc.req_b[2]  = 32'h0000_0055;
      ifc.req_valid = 4'b0100;
      @(posedge clk); #1;
      ifc.req_valid = '1;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (ifc.rsp_valid !== 1'b0 || ifc.req_ready !== '0 || ifc.rsp_id !== '0) begin
         errors++;
         $display("FAIL midreset_clear: valid=%b ready=%b id=%0d, required 0 0000 0",
                  ifc.rsp_valid, ifc.req_ready, ifc.rsp_id);
      end
      @(posedge clk); #2;
      rst_n = 1'b1;
      ifc.rsp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (ifc.req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL midreset_first: ready=%b, required 0001", ifc.req_ready);
      end
      @(posedge clk); #1;
      ifc.req_valid = '0;
      checks++;
      if (ifc.rsp_valid !== 1'b1 || ifc.rsp_id !== 2'd0) begin
         errors++;
         $display("FAIL midreset_rsp: valid=%b id=%0d, required 1 0", ifc.rsp_valid, ifc.rsp_id);
      end
      $display("reset_mid_op: first id after release %0d", ifc.rsp_id);
      @(posedge clk); #1;
      ifc.rsp_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c < 300; c++) begin
         @(posedge clk); #1;
         ifc.req_valid = R'($urandom);
         for (int i = 0; i < R; i++) begin
            case ($urandom_range(0, 3))
               0:       ifc.req_a[i] = '1;
               1:       ifc.req_a[i] = '0;
               default: ifc.req_a[i] = N'($urandom);
            endcase
            ifc.req_b[i]        = ($urandom_range(0, 3) == 0) ? '1 : N'($urandom);
            ifc.req_carry_in[i] = 1'($urandom);
         end
         ifc.rsp_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      ifc.req_valid = '0;
      ifc.rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (sb.size() != 0 || ifc.rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_outstanding: %0d results missing, rsp_valid=%b, required 0 and 0",
                  sb.size(), ifc.rsp_valid);
      end
      $display("back_to_back: 300 random cycles, outstanding %0d", sb.size());
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_fairness();
      test_single_request();
      test_backpressure();
      test_carry_overflow();
      test_reset_mid_op();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/adder_share_arbiter.md
ADDER_SHARE_ARBITER -- requirements
Module: adder_share_arbiter

Interface
REQ-001 SHALL have parameter N, default 32, meaning operand/sum width in bits (N >= 1).
REQ-002 SHALL have parameter R, default 4, meaning number of requesters (R >= 2); IW = max(1, clog2(R)).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port req_valid  input  R  per-requester operation request.
REQ-006 SHALL have port req_ready  output  R  per-requester accept; at most one bit high per cycle.
REQ-007 SHALL have port req_a  input  R x N  per-requester addend a.
REQ-008 SHALL have port req_b  input  R x N  per-requester addend b.
REQ-009 SHALL have port req_carry_in  input  R  per-requester carry in.
REQ-010 SHALL have port rsp_valid  output  1  result register holds a valid result.
REQ-011 SHALL have port rsp_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port rsp_id  output  IW  index of the requester that owns the result.
REQ-013 SHALL have port rsp_sum  output  N  sum bits, (a + b + carry_in) mod 2^N.
REQ-014 SHALL have port rsp_carry_out  output  1  bit N of a + b + carry_in.

Function
REQ-015 SHALL share one N-bit adder datapath among R requesters, one operation per accepted request.
REQ-016 SHALL implement FSM states EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-017 SHALL define can_accept = (state==EMPTY) or (rsp_valid and rsp_ready).
REQ-018 SHALL grant round-robin: search starts at requester (last_grant+1) mod R, wrapping; first req_valid found wins.
REQ-019 SHALL drive req_ready[i] = grant[i] and can_accept, combinationally; req_ready depends on req_valid, so requesters must not make req_valid depend on req_ready.
REQ-020 SHALL accept a transfer on requester i when req_valid[i] and req_ready[i] are both high.
REQ-021 SHALL update last_grant to i only on an accepted transfer; no update when idle or blocked.
REQ-022 SHALL register {rsp_carry_out, rsp_sum} = a + b + carry_in (N+1-bit, no truncation of carry) and rsp_id = i on accept; latency exactly 1 cycle.
REQ-023 Transitions: EMPTY->FULL on accept; FULL->EMPTY on rsp_ready without accept; FULL->FULL on simultaneous drain and accept, with the new result loaded (back-to-back throughput 1/cycle).
REQ-024 SHALL hold rsp_sum, rsp_carry_out and rsp_id stable while rsp_valid=1 and rsp_ready=0.
REQ-025 SHALL ignore rsp_ready in EMPTY.
REQ-026 SHALL keep all req_ready low when no req_valid is high, or when FULL and rsp_ready=0.
REQ-027 Overflow: all-ones + all-ones + 1 SHALL yield rsp_sum all-ones, rsp_carry_out 1.

Reset
REQ-028 On rst_n low, state SHALL go to EMPTY immediately, regardless of clock.
REQ-029 Reset values: rsp_valid 0, rsp_sum 0, rsp_carry_out 0, rsp_id 0, last_grant R-1, so requester 0 has priority first.
REQ-030 A result held at reset assertion SHALL be discarded; no req_ready high while rst_n is low.

Structure
REQ-031 Shared package SHALL hold the FSM state enum (EMPTY, FULL) and an IW-computing function/constant.
REQ-032 Round-robin grant logic SHALL be a sub-module rr_arbiter (inputs req, last_grant; output one-hot grant, grant index).
REQ-033 The adder SHALL be a single combinational N+1-bit adder feeding the result register; no per-requester adders.

Verification
REQ-034 Single request: N=32, req0 a=0x0000_0001, b=0xFFFF_FFFF, cin=0 -> next cycle rsp_valid=1, sum=0, cout=1, id=0.
REQ-035 Fairness: all 4 req_valid held high, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, one result per cycle.
REQ-036 Backpressure: rsp_ready=0 while FULL -> req_ready all 0, rsp outputs unchanged over 5 cycles; rsp_ready=1 -> drain and same-cycle accept.
REQ-037 Carry-in/overflow: a=b=0xFFFF_FFFF, cin=1 -> sum=0xFFFF_FFFF, cout=1.
REQ-038 Reset mid-operation: assert rst_n=0 between clock edges while FULL -> rsp_valid=0 immediately; after release, requester 0 wins first.
REQ-039 Scoreboard SHALL check sum/cout against a reference model and verify every accepted request produces exactly one response with the correct id.
